systolic_sequencer: RTL
=======================

SYSTOLIC_SEQUENCER -- requirements
Module: systolic_sequencer

Interface
REQ-001 SHALL have parameter INSTR_DEPTH, default 256, instruction memory depth (power of 2).
REQ-002 SHALL have parameter PC_WIDTH, default $clog2(INSTR_DEPTH), program counter width.
REQ-003 SHALL have parameter OP_ADDR_WIDTH, default 13, operand ADDR field width; instruction width = 19+OP_ADDR_WIDTH.
REQ-004 SHALL have parameter RETIRE_WIDTH, default 32, retired-instruction counter width.
REQ-005 clk  in  1  sole clock; one clock domain, all logic on posedge clk.
REQ-006 fsm_rst  in  1  reset, synchronous, active-high.
REQ-007 run  in  1  level; continuous execution while high.
REQ-008 step  in  1  pulse; execute one instruction from IDLE.
REQ-009 halt  in  1  level; abort to IDLE, highest priority.
REQ-010 rd_addr  out  PC_WIDTH  instruction memory read address.
REQ-011 rd_data  in  19+OP_ADDR_WIDTH  instruction word, valid 1 cycle after rd_addr.
REQ-012 load_en_left, load_en_top, swap_buffers_left, swap_buffers_top, shift_en_right, shift_en_down, acc_en, acc_out_we, acc_rst, buffer_rst_left, buffer_rst_top  out  1 each  single-cycle strobes.
REQ-013 addr_out  out  OP_ADDR_WIDTH  ADDR field of executing instruction; flags_out  out  5  FLAGS field.
REQ-014 pc_out  out  PC_WIDTH; curr_instr_out  out  instruction width; state_out  out  3; retired_cnt  out  RETIRE_WIDTH.

Function
REQ-015 Instruction bits, MSB first: LOAD_LEFT, LOAD_TOP, SWAP_LEFT, SWAP_TOP, SHIFT_RIGHT, SHIFT_DOWN, LOAD_ACC, WRITE_ACC_OUT, WAIT, JUMP, CLR, NOP, HALT, LOOP, FLAGS[4:0], ADDR[OP_ADDR_WIDTH-1:0].
REQ-016 States/state_out: IDLE=0, FETCH=1, EXEC=2, WAIT=3, DONE=4.
REQ-017 IDLE: run=1 -> FETCH; else step=1 -> FETCH (single-step); run and step together -> run behaviour.
REQ-018 FETCH: rd_addr=pc, one cycle, -> EXEC; curr_instr_out latches rd_data at end of EXEC's first edge (registered, visible during EXEC).
REQ-019 EXEC (one cycle): each set opcode bit pulses its strobe (LOAD_ACC->acc_en, WRITE_ACC_OUT->acc_out_we, CLR->acc_rst+buffer_rst_left+buffer_rst_top); addr_out/flags_out = instruction fields; retired_cnt +1 (wraps).
REQ-020 NOP set: no strobes, no WAIT/JUMP/LOOP/HALT action, pc+1.
REQ-021 PC priority in EXEC: HALT (pc unchanged, -> DONE) > JUMP (pc=ADDR[PC_WIDTH-1:0]) > LOOP > pc+1; pc INSTR_DEPTH-1 increments to 0.
REQ-022 LOOP, target ADDR[PC_WIDTH-1:0], count FLAGS: not armed and FLAGS=0 -> fall through; not armed, FLAGS>0 -> armed, loop_cnt=FLAGS-1, jump; armed, loop_cnt>0 -> loop_cnt-1, jump; armed, loop_cnt=0 -> disarm, fall through. Body runs FLAGS+1 times; single level, no nesting.
REQ-023 WAIT with ADDR=N>0: after EXEC, stay in WAIT exactly N cycles; N=0 -> no WAIT state. WAIT and HALT both set -> DONE, no wait.
REQ-024 Instruction completion (end of EXEC without wait, or last WAIT cycle): run=1 -> FETCH, else -> IDLE.
REQ-025 halt=1 in FETCH/EXEC/WAIT -> IDLE next cycle; in EXEC all strobes suppressed, pc, loop state, retired_cnt unchanged; in WAIT remaining cycles dropped, pc keeps advanced value.
REQ-026 DONE: all strobes 0, ignores run/step/halt; exits only via fsm_rst.
REQ-027 Strobes SHALL be 0 in every state except EXEC.

Reset
REQ-028 fsm_rst in any state: next cycle state IDLE, pc=0, loop disarmed, loop_cnt=0, wait counter=0, retired_cnt=0, curr_instr_out=0, addr_out=0, flags_out=0, rd_addr=0, all strobes 0; reset beats halt/run/step.

Verification
REQ-029 mem[0]=LOAD_LEFT|LOAD_TOP ADDR=5, mem[1]=HALT; run=1 -> FETCH, EXEC with load_en_left=load_en_top=1, addr_out=5, FETCH, EXEC, DONE; retired_cnt=2, pc_out=1.
REQ-030 mem[0]=WAIT ADDR=3, mem[1]=HALT, run=1 -> state_out=3 for exactly 3 cycles, then FETCH with rd_addr=1.
REQ-031 mem[0]=SHIFT_RIGHT, mem[1]=NOP, mem[2]=LOOP target 0 FLAGS=2, mem[3]=HALT -> 3 shift_en_right pulses, retired_cnt=10 at DONE.
REQ-032 run=0, one step pulse in IDLE -> exactly one EXEC, back to IDLE, pc_out=1; no further activity until next step.
REQ-033 halt asserted during EXEC of SHIFT_DOWN -> shift_en_down stays 0, next state IDLE, pc_out and retired_cnt unchanged.
REQ-034 mem[0]=JUMP ADDR=255, mem[255]=NOP, INSTR_DEPTH=256, run=1 -> pc 0,255,0 (wrap); fsm_rst mid-WAIT -> IDLE, all outputs 0 next cycle.

Source files
------------

// File: rtl/systolic_sequencer.sv
// Instruction sequencer for a systolic array: fetches control words, pulses
// per-instruction strobes, and handles WAIT delays, JUMP, single-level LOOP and HALT.
module systolic_sequencer #(
    parameter int INSTR_DEPTH   = 256,
    parameter int PC_WIDTH      = $clog2(INSTR_DEPTH),
    parameter int OP_ADDR_WIDTH = 13,
    parameter int RETIRE_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        fsm_rst,
    input  logic                        run,
    input  logic                        step,
    input  logic                        halt,
    output logic [PC_WIDTH-1:0]         rd_addr,
    input  logic [19+OP_ADDR_WIDTH-1:0] rd_data,
    output logic                        load_en_left,
    output logic                        load_en_top,
    output logic                        swap_buffers_left,
    output logic                        swap_buffers_top,
    output logic                        shift_en_right,
    output logic                        shift_en_down,
    output logic                        acc_en,
    output logic                        acc_out_we,
    output logic                        acc_rst,
    output logic                        buffer_rst_left,
    output logic                        buffer_rst_top,
    output logic [OP_ADDR_WIDTH-1:0]    addr_out,
    output logic [4:0]                  flags_out,
    output logic [PC_WIDTH-1:0]         pc_out,
    output logic [19+OP_ADDR_WIDTH-1:0] curr_instr_out,
    output logic [2:0]                  state_out,
    output logic [RETIRE_WIDTH-1:0]     retired_cnt
);
    localparam int IW = 19 + OP_ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                    state, state_nx;
    logic [PC_WIDTH-1:0]       pc, pc_nx;
    logic                      loop_armed, loop_armed_nx;
    logic [4:0]                loop_cnt, loop_cnt_nx;
    logic [OP_ADDR_WIDTH-1:0]  wait_cnt, wait_cnt_nx;
    logic [RETIRE_WIDTH-1:0]   retired_nx;
    logic [IW-1:0]             instr_q, instr;

    // The word is only on rd_data during EXEC; afterwards the registered copy holds it.
    assign instr = (state == S_EXEC) ? rd_data : instr_q;

    logic op_ll, op_lt, op_swl, op_swt, op_shr, op_shd, op_lacc, op_wacc;
    logic op_wait, op_jump, op_clr, op_nop, op_halt, op_loop;
    logic [4:0]               flags;
    logic [OP_ADDR_WIDTH-1:0] addr;
    logic [PC_WIDTH-1:0]      target;

    assign {op_ll, op_lt, op_swl, op_swt, op_shr, op_shd, op_lacc,
            op_wacc, op_wait, op_jump, op_clr, op_nop, op_halt, op_loop} = instr[IW-1:IW-14];
    assign flags  = instr[OP_ADDR_WIDTH+4:OP_ADDR_WIDTH];
    assign addr   = instr[OP_ADDR_WIDTH-1:0];
    assign target = addr[PC_WIDTH-1:0];

    logic fire;
    assign fire = (state == S_EXEC) && !halt && !op_nop;

    assign load_en_left      = fire && op_ll;
    assign load_en_top       = fire && op_lt;
    assign swap_buffers_left = fire && op_swl;
    assign swap_buffers_top  = fire && op_swt;
    assign shift_en_right    = fire && op_shr;
    assign shift_en_down     = fire && op_shd;
    assign acc_en            = fire && op_lacc;
    assign acc_out_we        = fire && op_wacc;
    assign acc_rst           = fire && op_clr;
    assign buffer_rst_left   = fire && op_clr;
    assign buffer_rst_top    = fire && op_clr;

    assign addr_out       = addr;
    assign flags_out      = flags;
    assign curr_instr_out = instr;
    assign rd_addr        = pc;
    assign pc_out         = pc;
    assign state_out      = state;

    always_comb begin
        state_t done_st;
        state_nx      = state;
        pc_nx         = pc;
        loop_armed_nx = loop_armed;
        loop_cnt_nx   = loop_cnt;
        wait_cnt_nx   = wait_cnt;
        retired_nx    = retired_cnt;
        done_st       = run ? S_FETCH : S_IDLE;
        case (state)
            S_IDLE:  if (!halt && (run || step)) state_nx = S_FETCH;
            S_FETCH: state_nx = halt ? S_IDLE : S_EXEC;
            S_EXEC: begin
                if (halt) begin
                    state_nx = S_IDLE;
                end else begin
                    retired_nx = retired_cnt + 1'b1;
                    if (op_nop) begin
                        pc_nx    = pc + 1'b1;
                        state_nx = done_st;
                    end else if (op_halt) begin
                        state_nx = S_DONE;
                    end else begin
                        if (op_jump) begin
                            pc_nx = target;
                        end else if (op_loop && loop_armed && loop_cnt != 5'd0) begin
                            loop_cnt_nx = loop_cnt - 5'd1;
                            pc_nx       = target;
                        end else if (op_loop && loop_armed) begin
                            loop_armed_nx = 1'b0;
                            pc_nx         = pc + 1'b1;
                        end else if (op_loop && flags != 5'd0) begin
                            loop_armed_nx = 1'b1;
                            loop_cnt_nx   = flags - 5'd1;
                            pc_nx         = target;
                        end else begin
                            pc_nx = pc + 1'b1;
                        end
                        if (op_wait && addr != '0) begin
                            state_nx    = S_WAIT;
                            wait_cnt_nx = addr;
                        end else begin
                            state_nx = done_st;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (halt) begin
                    state_nx    = S_IDLE;
                    wait_cnt_nx = '0;
                end else if (wait_cnt <= 1) begin
                    wait_cnt_nx = '0;
                    state_nx    = done_st;
                end else begin
                    wait_cnt_nx = wait_cnt - 1'b1;
                end
            end
            S_DONE:  state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (fsm_rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            loop_armed  <= 1'b0;
            loop_cnt    <= '0;
            wait_cnt    <= '0;
            retired_cnt <= '0;
            instr_q     <= '0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            loop_armed  <= loop_armed_nx;
            loop_cnt    <= loop_cnt_nx;
            wait_cnt    <= wait_cnt_nx;
            retired_cnt <= retired_nx;
            if (state == S_EXEC && !halt) instr_q <= rd_data;
        end
    end
endmodule
